// File: rtl/block_serial_adder_pkg.sv
// Shared state encoding and sizing helpers for the block-serial adder.
package block_serial_adder_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Slice counter width; never narrower than one bit, even for a single slice.
    function automatic int calc_cnt_w(input int w, input int bw);
        int n;
        n = w / bw;
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/block_serial_adder_if.sv
// Operand-in / result-out handshake bundle for the block-serial adder.
interface block_serial_adder_if #(
    parameter int width = 32
) ();
    logic             in_valid;
    logic             in_ready;
    logic [width-1:0] a;
    logic [width-1:0] b;
    logic             cin;
    logic             out_valid;
    logic             out_ready;
    logic [width-1:0] sum;
    logic             cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/block_serial_adder_adder_block.sv
// One block_width-bit ripple slice; the serial adder reuses it once per cycle.
module adder_block #(
    parameter int block_width = 4
) (
    input  logic [block_width-1:0] a,
    input  logic [block_width-1:0] b,
    input  logic                   cin,
    output logic [block_width-1:0] s,
    output logic                   cout
);
    logic [block_width:0] total;

    assign total     = {1'b0, a} + {1'b0, b} + {{block_width{1'b0}}, cin};
    assign {cout, s} = total;
endmodule

// File: rtl/block_serial_adder.sv
// Sequential adder: one block_width slice per cycle through a single adder_block,
// carry held in carry_q, result returned over a valid/ready handshake.
module block_serial_adder
    import block_serial_adder_pkg::*;
#(
    parameter int width       = 32,
    parameter int block_width = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    block_serial_adder_if.slave bus
);
    localparam int block_num = width / block_width;
    localparam int cnt_w     = calc_cnt_w(width, block_width);
    localparam int res_w     = (block_num > 1) ? width - block_width : 1;

    if (width % block_width != 0) begin : g_width_check
        $error("block_serial_adder: width must be a multiple of block_width");
    end

    logic [1:0]             state_q, state_d;
    logic [cnt_w-1:0]       k_q, k_d;
    logic                   carry_q, carry_d;
    logic [width-1:0]       a_sh_q, a_sh_d;
    logic [width-1:0]       b_sh_q, b_sh_d;
    logic [res_w-1:0]       res_sh_q, res_sh_d;
    logic [width-1:0]       sum_q, sum_d;
    logic                   cout_q, cout_d;

    logic [block_width-1:0] slice_sum;
    logic                   slice_cout;
    logic [width-1:0]       res_next;
    logic [res_w-1:0]       res_keep;
    logic                   in_fire, out_fire, last_slice;

    adder_block #(.block_width(block_width)) u_slice (
        .a    (a_sh_q[block_width-1:0]),
        .b    (b_sh_q[block_width-1:0]),
        .cin  (carry_q),
        .s    (slice_sum),
        .cout (slice_cout)
    );

    // Slices enter at the MSB end so the last one lands the word in place.
    if (block_num > 1) begin : g_multi
        assign res_next = {slice_sum, res_sh_q};
        assign res_keep = res_next[width-1:block_width];
    end else begin : g_single
        assign res_next = slice_sum;
        assign res_keep = res_sh_q;
    end

    assign bus.in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && bus.out_ready);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;

    assign in_fire    = bus.in_valid && bus.in_ready;
    assign out_fire   = bus.out_valid && bus.out_ready;
    assign last_slice = (k_q == cnt_w'(block_num - 1));

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        carry_d  = carry_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        case (state_q)
            ST_BUSY: begin
                carry_d  = slice_cout;
                a_sh_d   = a_sh_q >> block_width;
                b_sh_d   = b_sh_q >> block_width;
                res_sh_d = res_keep;
                k_d      = k_q + cnt_w'(1);
                if (last_slice) begin
                    state_d = ST_DONE;
                    sum_d   = res_next;
                    cout_d  = slice_cout;
                end
            end
            ST_DONE: begin
                if (out_fire) state_d = ST_IDLE;
            end
            ST_IDLE: ;
            default: state_d = ST_IDLE;
        endcase
        // A retiring result and a new operand pair may share the same edge.
        if (in_fire) begin
            state_d = ST_BUSY;
            a_sh_d  = bus.a;
            b_sh_d  = bus.b;
            carry_d = bus.cin;
            k_d     = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            k_q      <= '0;
            carry_q  <= 1'b0;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            carry_q  <= carry_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end
endmodule

// File: tb/tb_block_serial_adder.sv
// Directed bench for block_serial_adder at block_width 4, 8 and 32 (width 32).
module tb_block_serial_adder;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [1:0]  sel = 2'd0;
    logic        tb_in_valid = 1'b0;
    logic        tb_out_ready = 1'b0;
    logic [31:0] tb_a = '0;
    logic [31:0] tb_b = '0;
    logic        tb_cin = 1'b0;

    logic        m_in_ready, m_out_valid, m_cout;
    logic [31:0] m_sum;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 clk = ~clk;

    block_serial_adder_if #(.width(32)) bus4 ();
    block_serial_adder_if #(.width(32)) bus8 ();
    block_serial_adder_if #(.width(32)) bus32 ();

    block_serial_adder #(.width(32), .block_width(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(bus4));
    block_serial_adder #(.width(32), .block_width(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    block_serial_adder #(.width(32), .block_width(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    assign bus4.a  = tb_a;   assign bus4.b  = tb_b;   assign bus4.cin  = tb_cin;
    assign bus8.a  = tb_a;   assign bus8.b  = tb_b;   assign bus8.cin  = tb_cin;
    assign bus32.a = tb_a;   assign bus32.b = tb_b;   assign bus32.cin = tb_cin;
    assign bus4.in_valid   = tb_in_valid  && (sel == 2'd0);
    assign bus8.in_valid   = tb_in_valid  && (sel == 2'd1);
    assign bus32.in_valid  = tb_in_valid  && (sel == 2'd2);
    assign bus4.out_ready  = tb_out_ready && (sel == 2'd0);
    assign bus8.out_ready  = tb_out_ready && (sel == 2'd1);
    assign bus32.out_ready = tb_out_ready && (sel == 2'd2);

    assign m_in_ready  = (sel == 2'd0) ? bus4.in_ready  : (sel == 2'd1) ? bus8.in_ready  : bus32.in_ready;
    assign m_out_valid = (sel == 2'd0) ? bus4.out_valid : (sel == 2'd1) ? bus8.out_valid : bus32.out_valid;
    assign m_sum       = (sel == 2'd0) ? bus4.sum       : (sel == 2'd1) ? bus8.sum       : bus32.sum;
    assign m_cout      = (sel == 2'd0) ? bus4.cout      : (sel == 2'd1) ? bus8.cout      : bus32.cout;

    // Latency counts rising edges from the capturing edge (inclusive) to out_valid visible.
    task automatic run_op(input logic [1:0] sel_i, input logic [31:0] ai, input logic [31:0] bi,
                          input logic ci, output logic [31:0] s, output logic co,
                          output int lat, output logic busy_rdy);
        int w;
        sel = sel_i;
        tb_out_ready = 1'b0;
        tb_a = ai; tb_b = bi; tb_cin = ci;
        tb_in_valid = 1'b1;
        #1;
        w = 0;
        while (!m_in_ready && w < 40) begin @(posedge clk); #1; w++; end
        @(posedge clk); #1;
        tb_in_valid = 1'b0;
        busy_rdy = m_in_ready;
        lat = 1;
        while (!m_out_valid && lat < 60) begin @(posedge clk); #1; lat++; end
        s = m_sum;
        co = m_cout;
        tb_out_ready = 1'b1;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] s; logic co, br; int lat; int stray;
        sel = 2'd0;
        #1;
        total_cnt++;
        if ({m_in_ready, m_out_valid, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 32'h0})
            $display("FAIL reset_state: rdy=%b vld=%b cout=%b sum=%h, required rdy=1 vld=0 cout=0 sum=0",
                     m_in_ready, m_out_valid, m_cout, m_sum);
        else pass_cnt++;
        @(posedge clk); #1; rst_n = 1'b1;
        // Start an op, let three slices run, then reset mid-BUSY.
        tb_a = 32'hDEAD_BEEF; tb_b = 32'h0BAD_F00D; tb_cin = 1'b1; tb_in_valid = 1'b1;
        @(posedge clk); #1; tb_in_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if ({m_in_ready, m_out_valid, m_sum} !== {1'b1, 1'b0, 32'h0})
            $display("FAIL reset_mid_busy: rdy=%b vld=%b sum=%h, required rdy=1 vld=0 sum=0",
                     m_in_ready, m_out_valid, m_sum);
        else pass_cnt++;
        @(posedge clk); #1; rst_n = 1'b1;
        tb_out_ready = 1'b1;
        stray = 0;
        repeat (12) begin @(posedge clk); #1; if (m_out_valid) stray++; end
        tb_out_ready = 1'b0;
        total_cnt++;
        if (stray !== 0) $display("FAIL reset_no_partial: out_valid cycles=%0d, required 0", stray);
        else pass_cnt++;
        run_op(2'd0, 32'd5, 32'd7, 1'b0, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b0, 32'hC}) $display("FAIL reset_next_op: got %b_%h, required 0_0000000c", co, s);
        else pass_cnt++;
        $display("reset test: post-reset op 5+7 -> sum=%h latency=%0d", s, lat);
    endtask

    task automatic test_basic();
        logic [31:0] s; logic co, br; int lat;
        run_op(2'd0, 32'h1234_5678, 32'h1111_1111, 1'b0, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b0, 32'h2345_6789}) $display("FAIL basic_sum: got %b_%h, required 0_23456789", co, s);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 9) $display("FAIL basic_latency: got %0d edges, required 9", lat);
        else pass_cnt++;
        total_cnt++;
        if (br !== 1'b0) $display("FAIL busy_in_ready: got %b, required 0", br);
        else pass_cnt++;
        $display("basic: sum=%h cout=%b latency=%0d", s, co, lat);
    endtask

    task automatic test_carry();
        logic [31:0] s; logic co, br; int lat;
        run_op(2'd0, 32'hFFFF_FFFF, 32'h0, 1'b1, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b1, 32'h0}) $display("FAIL carry_ripple: got %b_%h, required 1_00000000", co, s);
        else pass_cnt++;
        $display("carry: FFFFFFFF+0+1 -> cout=%b sum=%h", co, s);
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b1, 32'hFFFF_FFFF}) $display("FAIL carry_max: got %b_%h, required 1_ffffffff", co, s);
        else pass_cnt++;
        $display("carry: FFFFFFFF+FFFFFFFF+1 -> cout=%b sum=%h", co, s);
    endtask

    task automatic test_backpressure();
        int w;
        sel = 2'd0; tb_out_ready = 1'b0;
        tb_a = 32'h0F0F_0F0F; tb_b = 32'h0101_0101; tb_cin = 1'b1; tb_in_valid = 1'b1;
        @(posedge clk); #1; tb_in_valid = 1'b0;
        w = 0;
        while (!m_out_valid && w < 40) begin @(posedge clk); #1; w++; end
        for (int i = 0; i < 5; i++) begin
            total_cnt++;
            if ({m_out_valid, m_in_ready, m_cout, m_sum} !== {1'b1, 1'b0, 1'b0, 32'h1010_1011})
                $display("FAIL stall_hold[%0d]: vld=%b rdy=%b cout=%b sum=%h, required vld=1 rdy=0 cout=0 sum=10101011",
                         i, m_out_valid, m_in_ready, m_cout, m_sum);
            else pass_cnt++;
            @(posedge clk); #1;
        end
        tb_out_ready = 1'b1;
        #1;
        total_cnt++;
        if (m_in_ready !== 1'b1) $display("FAIL done_in_ready: got %b, required 1", m_in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        tb_out_ready = 1'b0;
        total_cnt++;
        if ({m_out_valid, m_sum} !== {1'b0, 32'h1010_1011})
            $display("FAIL retire: vld=%b sum=%h, required vld=0 sum=10101011", m_out_valid, m_sum);
        else pass_cnt++;
        $display("backpressure: held 5 cycles then retired, sum=%h", m_sum);
    endtask

    task automatic test_back_to_back();
        logic [32:0] exp_q[$];
        logic [32:0] exp;
        int issued, retired, cyc, first_cap, last_cap;
        logic cap;
        sel = 2'd0;
        tb_a = $urandom; tb_b = $urandom; tb_cin = 1'($urandom_range(0, 1));
        tb_in_valid = 1'b1; tb_out_ready = 1'b1;
        #1;
        issued = 0; retired = 0; cyc = 0; first_cap = 0; last_cap = 0;
        while (retired < 100 && cyc < 3000) begin
            if (m_out_valid) begin
                exp = exp_q.pop_front();
                total_cnt++;
                if ({m_cout, m_sum} !== exp)
                    $display("FAIL b2b_result[%0d]: got %b_%h, required %b_%h",
                             retired, m_cout, m_sum, exp[32], exp[31:0]);
                else pass_cnt++;
                $display("b2b op %0d: cout=%b sum=%h", retired, m_cout, m_sum);
                retired++;
            end
            cap = m_in_ready && tb_in_valid;
            @(posedge clk); #1; cyc++;
            if (cap) begin
                exp_q.push_back({1'b0, tb_a} + {1'b0, tb_b} + {32'h0, tb_cin});
                if (issued == 0) first_cap = cyc;
                last_cap = cyc;
                issued++;
                if (issued < 100) begin
                    tb_a = $urandom; tb_b = $urandom; tb_cin = 1'($urandom_range(0, 1));
                end else tb_in_valid = 1'b0;
            end
        end
        tb_out_ready = 1'b0;
        total_cnt++;
        if (retired !== 100) $display("FAIL b2b_count: retired %0d, required 100", retired);
        else pass_cnt++;
        total_cnt++;
        if (last_cap - first_cap !== 99 * 9)
            $display("FAIL b2b_throughput: %0d cycles for 99 intervals, required %0d", last_cap - first_cap, 99 * 9);
        else pass_cnt++;
        @(posedge clk); #1;
    endtask

    task automatic test_sweep();
        logic [31:0] s, ra, rb; logic co, br, rc; int lat;
        run_op(2'd1, 32'h89AB_CDEF, 32'h7654_3210, 1'b1, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b1, 32'h0}) $display("FAIL bw8_sum: got %b_%h, required 1_00000000", co, s);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 5) $display("FAIL bw8_latency: got %0d, required 5", lat);
        else pass_cnt++;
        $display("bw8: cout=%b sum=%h latency=%0d", co, s, lat);
        run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 1'b0, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b1, 32'h0}) $display("FAIL bw32_sum: got %b_%h, required 1_00000000", co, s);
        else pass_cnt++;
        total_cnt++;
        if (lat !== 2) $display("FAIL bw32_latency: got %0d, required 2", lat);
        else pass_cnt++;
        $display("bw32: cout=%b sum=%h latency=%0d", co, s, lat);
        run_op(2'd2, 32'h0000_FFFF, 32'h0000_0001, 1'b0, s, co, lat, br);
        total_cnt++;
        if ({co, s} !== {1'b0, 32'h0001_0000}) $display("FAIL bw32_mid: got %b_%h, required 0_00010000", co, s);
        else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
            run_op((i % 2 == 0) ? 2'd1 : 2'd2, ra, rb, rc, s, co, lat, br);
            total_cnt++;
            if ({co, s} !== ({1'b0, ra} + {1'b0, rb} + {32'h0, rc}))
                $display("FAIL sweep_rand[%0d]: %h+%h+%b got %b_%h", i, ra, rb, rc, co, s);
            else pass_cnt++;
            total_cnt++;
            if (lat !== ((i % 2 == 0) ? 5 : 2))
                $display("FAIL sweep_latency[%0d]: got %0d, required %0d", i, lat, (i % 2 == 0) ? 5 : 2);
            else pass_cnt++;
            $display("sweep op %0d: %h+%h+%b -> %b_%h latency=%0d", i, ra, rb, rc, co, s, lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_carry();
        test_backpressure();
        test_back_to_back();
        test_sweep();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", pass_cnt, total_cnt);
        $fatal(1, "watchdog");
    end

endmodule
